sw_read_logic: RTL and testbench
================================

SW_READ_LOGIC -- requirements
Module: sw_read_logic

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 8: number of switch inputs, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable synchronized cycles required to accept a new level, minimum 2.
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port S_AXI_ARESET, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port slv_reg_rden, input, 1 bit: AXI read strobe, one cycle per accepted read.
REQ-006 SHALL have port axi_araddr, input, 3 bits: read byte address.
REQ-007 SHALL have port SW, input, SW_WIDTH bits: raw switch levels, asynchronous to the clock.
REQ-008 SHALL have port reg_data_out, output, 32 bits: registered read data.
REQ-009 SHALL have port sw_irq, output, 1 bit: high while any edge flag is set.

Function
REQ-010 SHALL pass each SW bit through a two-flop synchronizer before any other use.
REQ-011 SHALL keep, per bit, a debounce counter that clears whenever the synchronized bit equals the debounced bit.
REQ-012 SHALL increment the counter while the synchronized bit differs from the debounced bit, and on the cycle the count reaches DEBOUNCE_CYCLES-1 SHALL update the debounced bit and clear the counter.
REQ-013 SHALL clear the counter, without updating the debounced bit, when the input reverts before the threshold (glitch rejection).
REQ-014 SHALL size the counter as clog2(DEBOUNCE_CYCLES) bits; the counter never wraps.
REQ-015 SHALL set edge_flag[i] on the cycle debounced[i] goes 0->1; falling edges set no flag.
REQ-016 SHALL, on a clock edge with slv_reg_rden=1, load reg_data_out with: address 3'h0 -> zero-extended debounced[SW_WIDTH-1:0]; address 3'h4 -> zero-extended edge_flag; any other address -> 32'h0.
REQ-017 SHALL give one cycle of read latency: data is valid the cycle after slv_reg_rden and holds until the next read.
REQ-018 SHALL clear all edge flags on the same edge as a read of 3'h4 (clear-on-read).
REQ-019 SHALL, when a new rising edge and a clear-on-read of 3'h4 coincide, keep that bit's flag set after the edge, because set wins; the returned data shows the pre-edge flag value.
REQ-020 SHALL leave level reads (3'h0) without side effects.
REQ-021 SHALL drive sw_irq as a registered OR of edge_flag, asserting one cycle after a flag sets and deasserting one cycle after the flags clear.

Reset
REQ-022 SHALL, on S_AXI_ARESET=1 and regardless of the clock, clear synchronizers, debounced bits, counters, edge flags, reg_data_out (32'h0) and sw_irq (0).
REQ-023 SHALL abandon any debounce in progress at reset; after reset release, switches held high produce one rising edge after DEBOUNCE_CYCLES plus synchronizer delay.
REQ-024 SHALL resume normal operation on the first clock edge after reset deasserts.

Structure
REQ-025 SHALL take the address constants (ADDR_SW_LEVEL=3'h0, ADDR_SW_EDGE=3'h4) from shared package led_ip_pkg, which also holds the LED write address used by the write-side logic.
REQ-026 SHALL instantiate SW_WIDTH copies of sub-module sw_debounce (one bit: synchronizer, counter, debounced output, rise pulse) via a generate loop; flags, read mux and irq stay in sw_read_logic.

Verification (SW_WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-027 SHALL check debounce: SW=8'h05 held 10 cycles, then read 3'h0 -> reg_data_out=32'h05, edge read returns 32'h05, sw_irq=1 before the read.
REQ-028 SHALL check glitch rejection: SW bit 3 pulsed high for 3 cycles -> read 3'h0 returns 32'h0 and sw_irq remains 0.
REQ-029 SHALL check clear-on-read: after flags=8'h05, read 3'h4 -> 32'h05; second read 3'h4 -> 32'h0; sw_irq low 1 cycle after the first read.
REQ-030 SHALL check the coincident case: bit 1 debounces high on the same cycle as a 3'h4 read -> that read omits bit 1, next read returns 32'h02.
REQ-031 SHALL check reset mid-debounce: SW=8'hFF, assert reset after 2 cycles -> all outputs 0 immediately; after release, flags=8'hFF after at least 6 cycles.
REQ-032 SHALL check an unmapped address: read 3'h2 -> 32'h0 and edge flags unchanged.

Source files
------------

// File: rtl/led_ip_pkg.sv
// Shared register map and read-select decode for the LED/switch AXI peripheral.
package led_ip_pkg;

  localparam logic [2:0] ADDR_LED_OUT  = 3'h0;
  localparam logic [2:0] ADDR_SW_LEVEL = 3'h0;
  localparam logic [2:0] ADDR_SW_EDGE  = 3'h4;

  typedef enum logic [1:0] {
    RSEL_LEVEL,
    RSEL_EDGE,
    RSEL_NONE
  } rd_sel_e;

  function automatic rd_sel_e decode_rd_addr(input logic [2:0] addr);
    rd_sel_e sel;
    sel = RSEL_NONE;
    if (addr == ADDR_SW_LEVEL) sel = RSEL_LEVEL;
    else if (addr == ADDR_SW_EDGE) sel = RSEL_EDGE;
    return sel;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchronizer, stability counter, debounced level and rise pulse.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_o = 1'b0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync_q[1];
        rise_o = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/sw_read_logic.sv
// Switch read side of the AXI peripheral: per-bit debounce, sticky rising-edge flags, read mux, irq.
module sw_read_logic
  import led_ip_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic                slv_reg_rden,
  input  logic [2:0]          axi_araddr,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [31:0]         reg_data_out,
  output logic                sw_irq
);

  logic [SW_WIDTH-1:0] db;
  logic [SW_WIDTH-1:0] rise;
  logic [SW_WIDTH-1:0] flag_q, flag_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                irq_q;
  rd_sel_e             rd_sel;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (S_AXI_ACLK),
      .rst_i (S_AXI_ARESET),
      .sw_i  (SW[g]),
      .db_o  (db[g]),
      .rise_o(rise[g])
    );
  end

  assign rd_sel = decode_rd_addr(axi_araddr);

  // Clear-on-read is applied before OR-ing in new rises, so a coincident rise survives.
  always_comb begin
    flag_d    = flag_q;
    rd_data_d = rd_data_q;
    if (slv_reg_rden) begin
      rd_data_d = '0;
      unique case (rd_sel)
        RSEL_LEVEL: rd_data_d[SW_WIDTH-1:0] = db;
        RSEL_EDGE: begin
          rd_data_d[SW_WIDTH-1:0] = flag_q;
          flag_d                  = '0;
        end
        default: ;
      endcase
    end
    flag_d = flag_d | rise;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      flag_q    <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      rd_data_q <= rd_data_d;
      irq_q     <= |flag_q;
    end
  end

  assign reg_data_out = rd_data_q;
  assign sw_irq       = irq_q;

endmodule

// File: tb/tb_sw_read_logic.sv
// Scoreboard bench for sw_read_logic with SW_WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_sw_read_logic;

  logic        clk;
  logic        rst;
  logic        rden;
  logic [2:0]  addr;
  logic [7:0]  sw;
  logic [31:0] rdata;
  logic        irq;

  int errors;
  int checks;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen;

  sw_read_logic #(
    .SW_WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .slv_reg_rden(rden),
    .axi_araddr  (addr),
    .SW          (sw),
    .reg_data_out(rdata),
    .sw_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    rden = 1'b1;
    addr = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick(1);
    rden = 1'b0;
    addr = 3'h0;
  endtask

  always @(posedge clk) rd_seen <= rden;

  always @(negedge clk) begin
    if (rd_seen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        check(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    rden   = 1'b0;
    addr   = 3'h0;
    sw     = 8'h00;
    #3;
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Debounce of a stable pattern
    sw = 8'h05;
    tick(10);
    check("debounce_irq_before_read", {31'h0, irq}, 32'h1);
    do_read("debounce_level", 3'h0, 32'h05);
    do_read("debounce_edge", 3'h4, 32'h05);
    tick(1);
    check("irq_after_clear", {31'h0, irq}, 32'h0);
    do_read("clear_on_read_second", 3'h4, 32'h0);

    // Three-cycle glitch on bit 3 must be rejected
    sw = 8'h0D;
    tick(3);
    sw = 8'h05;
    tick(10);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    do_read("glitch_level", 3'h0, 32'h05);
    do_read("glitch_edge", 3'h4, 32'h0);

    // Bit 1 debounces on the same edge as an edge read
    sw = 8'h07;
    tick(5);
    do_read("coincident_read", 3'h4, 32'h0);
    do_read("coincident_next", 3'h4, 32'h02);

    // Unmapped addresses return zero without touching flags
    sw = 8'h87;
    tick(10);
    do_read("unmapped_2", 3'h2, 32'h0);
    do_read("unmapped_6", 3'h6, 32'h0);
    do_read("flags_after_unmapped", 3'h4, 32'h80);
    do_read("level_87", 3'h0, 32'h87);

    // Falling edge sets no flag
    sw = 8'h07;
    tick(10);
    check("fall_irq", {31'h0, irq}, 32'h0);
    do_read("fall_edge", 3'h4, 32'h0);
    do_read("fall_level", 3'h0, 32'h07);

    // Reset in the middle of a debounce
    sw = 8'h87;
    tick(10);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    do_read("pre_reset_level", 3'h0, 32'h87);
    sw = 8'hFF;
    tick(2);
    check("read_data_holds", rdata, 32'h87);
    rst = 1'b1;
    #1;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("post_reset_irq_early", {31'h0, irq}, 32'h0);
    tick(3);
    check("post_reset_irq", {31'h0, irq}, 32'h1);
    do_read("post_reset_edge", 3'h4, 32'hFF);
    do_read("post_reset_level", 3'h0, 32'hFF);

    tick(2);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
